ftb_port_arb: RTL and testbench
===============================

Name: ftb_port_arb

Overview:
- Arbitrates the single-ported FTB between the BPU lookup pipeline and backend predictor-update traffic.
- Buffers backend update requests in a small in-order queue.
- Decides each cycle whether the FTB port serves a lookup or an update, and runs the update handshake to the FTB.
- Raises a stall so the BPU freezes base_pc advance while the port is busy with an update.
- Sits between the backend/FTQ update path and the FTB, beside the BPU.

Parameters:
- QDEPTH, 4, update queue entries; power of two, ≥2.
- MAX_STARVE, 8, number of consecutive granted lookups allowed while the queue is non-empty before an update is forced.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- i_upd_vld  input  1  backend update request valid.
- o_upd_rdy  output  1  queue can accept an update.
- i_upd_info  input  BPupdateInfo_t  update payload (startAddr, ftb_update).
- i_lkp_req  input  1  BPU lookup request.
- o_lkp_gnt  output  1  lookup granted this cycle.
- o_ftb_upd_req  output  1  update request to FTB.
- o_ftb_upd_info  output  BPupdateInfo_t  head-of-queue payload to FTB.
- i_ftb_upd_done  input  1  FTB update-finished pulse, one cycle.
- o_bpu_stall  output  1  BPU must hold base_pc and its pipeline registers.
- o_q_count  output  $clog2(QDEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - Queue emptied; rd/wr pointers and count go to 0; starve counter goes to 0; FSM goes to IDLE.
  - Outputs: o_upd_rdy=1, o_lkp_gnt=0, o_ftb_upd_req=0, o_bpu_stall=0, o_q_count=0, o_ftb_upd_info=0.
  - Reset asserted mid-update drops the in-flight update and every queued update; no retry after reset.
- Queue:
  - Enqueue when i_upd_vld && o_upd_rdy, with o_upd_rdy = (count != QDEPTH).
  - o_upd_rdy does not look ahead to a same-cycle pop.
  - Pop on i_ftb_upd_done while in UPD.
  - Enqueue and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QDEPTH.
  - o_ftb_upd_info is the head entry at all times; it is meaningful only while o_ftb_upd_req=1.
- Selection, combinational in IDLE only:
  - upd_sel = !empty && (!i_lkp_req || starve==MAX_STARVE || full).
  - o_lkp_gnt = (state==IDLE) && i_lkp_req && !upd_sel.
- Starve counter:
  - +1 on each cycle with o_lkp_gnt && !empty; saturates at MAX_STARVE.
  - Cleared on the IDLE->UPD transition.
  - Cleared when the queue is empty.
- FSM:
  - IDLE: if upd_sel, go to UPD next cycle; no lookup grant in this cycle.
  - UPD: o_ftb_upd_req=1 and held until i_ftb_upd_done. On done: pop, go to GAP. A done outside UPD is ignored.
  - GAP: one turnaround cycle. No grant, no update request. Always returns to IDLE.
- o_bpu_stall = (state!=IDLE) || upd_sel. It is combinational from state and queue.
- Minimum port occupancy per update is 3 cycles (select, UPD with done, GAP).
- A lookup is never granted while o_ftb_upd_req=1 or in GAP.
- Updates reach the FTB in enqueue order; no reordering or merging.

Optional Feature:
- Macro: FTB_ARB_PERF_EN.
- When defined:
  - Adds outputs o_perf_upd_cnt [31:0] and o_perf_lkp_block_cnt [31:0].
  - o_perf_upd_cnt counts completed updates (i_ftb_upd_done in UPD).
  - o_perf_lkp_block_cnt counts cycles with i_lkp_req && !o_lkp_gnt.
  - Both wrap at 2^32 and clear on reset.
- When not defined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then i_lkp_req=1 with the queue empty for 20 cycles -> o_lkp_gnt=1 every cycle; o_bpu_stall=0; o_q_count=0.
- i_lkp_req=0; enqueue 1 update; FTB returns done 2 cycles after the request -> select occurs the cycle after enqueue; o_ftb_upd_req high for exactly 2 cycles; then 1 GAP cycle; o_q_count 1->0 on the done cycle.
- i_lkp_req held at 1; enqueue 1 update -> exactly 8 lookups granted, then a forced update; o_lkp_gnt=0 from the select cycle through GAP.
- i_lkp_req=1; enqueue 4 updates back-to-back -> o_upd_rdy=0 when count=4; the update is forced immediately on full; a 5th i_upd_vld is not accepted until the first pop.
- Enqueue and a done pulse in the same cycle at count=2 -> count stays 2; the next o_ftb_upd_info is the second-oldest entry.
- Drive rst low while o_ftb_upd_req=1 with 3 entries queued -> o_ftb_upd_req drops without waiting for a clock edge; o_q_count=0; after release, lookups are granted with no residual update.

Source files
------------

// File: rtl/ftb_port_arb.sv
// FTB port arbiter: shares the single FTB port between BPU lookups and queued backend updates.
// Optional performance counters are enabled by defining FTB_ARB_PERF_EN.
package ftb_arb_pkg;
  typedef struct packed {
    logic [38:0] startAddr;
    logic [31:0] ftb_update;
  } BPupdateInfo_t;
endpackage

module ftb_port_arb
  import ftb_arb_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_upd_vld,
  output logic                      o_upd_rdy,
  input  BPupdateInfo_t             i_upd_info,
  input  logic                      i_lkp_req,
  output logic                      o_lkp_gnt,
  output logic                      o_ftb_upd_req,
  output BPupdateInfo_t             o_ftb_upd_info,
  input  logic                      i_ftb_upd_done,
  output logic                      o_bpu_stall,
  output logic [$clog2(QDEPTH):0]   o_q_count
`ifdef FTB_ARB_PERF_EN
  ,
  output logic [31:0]               o_perf_upd_cnt,
  output logic [31:0]               o_perf_lkp_block_cnt
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [AW:0]   QFULL      = (AW + 1)'(QDEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UPD  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  BPupdateInfo_t r_mem [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_upd_sel;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == QFULL);
  assign o_upd_rdy = !w_full;
  assign w_push    = i_upd_vld && o_upd_rdy;
  assign w_pop     = (r_state == UPD) && i_ftb_upd_done;

  // Updates win the idle port when no lookup wants it, a lookup streak hit the limit, or the queue is full.
  assign w_upd_sel = (r_state == IDLE) && !w_empty &&
                     (!i_lkp_req || (r_starve == STARVE_MAX) || w_full);

  assign o_lkp_gnt      = (r_state == IDLE) && i_lkp_req && !w_upd_sel;
  assign o_ftb_upd_req  = (r_state == UPD);
  assign o_bpu_stall    = (r_state != IDLE) || w_upd_sel;
  assign o_q_count      = r_count;
  assign o_ftb_upd_info = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_upd_info;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_upd_sel || w_empty) begin
      r_starve <= '0;
    end else if (o_lkp_gnt && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_upd_sel) w_state_nxt = UPD;
      UPD:     if (i_ftb_upd_done) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

`ifdef FTB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_upd_cnt       <= '0;
      o_perf_lkp_block_cnt <= '0;
    end else begin
      if (w_pop) o_perf_upd_cnt <= o_perf_upd_cnt + 32'd1;
      if (i_lkp_req && !o_lkp_gnt) o_perf_lkp_block_cnt <= o_perf_lkp_block_cnt + 32'd1;
    end
  end
`else
  // Performance counters are absent in this build.
`endif

endmodule

// File: tb/tb_ftb_port_arb.sv
// Scoreboard bench for ftb_port_arb: a port-ownership model predicts every cycle's outputs and the update order.
module tb_ftb_port_arb;
  import ftb_arb_pkg::*;

  localparam int QDEPTH     = 4;
  localparam int MAX_STARVE = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_upd_vld;
  logic          o_upd_rdy;
  BPupdateInfo_t i_upd_info;
  logic          i_lkp_req;
  logic          o_lkp_gnt;
  logic          o_ftb_upd_req;
  BPupdateInfo_t o_ftb_upd_info;
  logic          i_ftb_upd_done;
  logic          o_bpu_stall;
  logic [2:0]    o_q_count;
`ifdef FTB_ARB_PERF_EN
  logic [31:0]   o_perf_upd_cnt;
  logic [31:0]   o_perf_lkp_block_cnt;
`endif

  ftb_port_arb #(.QDEPTH(QDEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_upd_vld      (i_upd_vld),
    .o_upd_rdy      (o_upd_rdy),
    .i_upd_info     (i_upd_info),
    .i_lkp_req      (i_lkp_req),
    .o_lkp_gnt      (o_lkp_gnt),
    .o_ftb_upd_req  (o_ftb_upd_req),
    .o_ftb_upd_info (o_ftb_upd_info),
    .i_ftb_upd_done (i_ftb_upd_done),
    .o_bpu_stall    (o_bpu_stall),
    .o_q_count      (o_q_count)
`ifdef FTB_ARB_PERF_EN
    ,
    .o_perf_upd_cnt       (o_perf_upd_cnt),
    .o_perf_lkp_block_cnt (o_perf_lkp_block_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic gnt;
    logic stall;
    logic rdy;
    logic req;
    int   count;
    logic pop;
  } exp_t;

  exp_t          expCycle[$];
  BPupdateInfo_t expUpd[$];

  int nChecks = 0;
  int nFails  = 0;

  // Port-ownership model: 0 = port free, 1 = update in flight, 2 = turnaround.
  int mCount  = 0;
  int mPhase  = 0;
  int mStarve = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkInfo(input string name, input BPupdateInfo_t got, input BPupdateInfo_t want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic BPupdateInfo_t randInfo();
    logic [95:0] raw;
    raw = {$urandom(), $urandom(), $urandom()};
    return BPupdateInfo_t'(raw[70:0]);
  endfunction

  // One cycle of stimulus; the model's prediction for this cycle goes to the scoreboard.
  task automatic applyStimulus(input logic lkp, input logic vld, input BPupdateInfo_t info, input logic done);
    exp_t e;
    logic mEmpty, mFull, sel, accept;
    @(negedge clk);
    i_lkp_req      = lkp;
    i_upd_vld      = vld;
    i_upd_info     = info;
    i_ftb_upd_done = done;

    mEmpty  = (mCount == 0);
    mFull   = (mCount == QDEPTH);
    sel     = (mPhase == 0) && !mEmpty && (!lkp || mStarve >= MAX_STARVE || mFull);
    e.gnt   = (mPhase == 0) && lkp && !sel;
    e.stall = (mPhase != 0) || sel;
    e.rdy   = !mFull;
    e.req   = (mPhase == 1);
    e.count = mCount;
    e.pop   = (mPhase == 1) && done;
    expCycle.push_back(e);

    accept = vld && !mFull;
    if (accept) expUpd.push_back(info);
    mCount = mCount + (accept ? 1 : 0) - (e.pop ? 1 : 0);

    if (sel || mEmpty)                       mStarve = 0;
    else if (e.gnt && mStarve < MAX_STARVE)  mStarve++;

    case (mPhase)
      0:       if (sel) mPhase = 1;
      1:       if (done) mPhase = 2;
      default: mPhase = 0;
    endcase
  endtask

  task automatic idleCycles(input logic lkp, input int n);
    for (int i = 0; i < n; i++) applyStimulus(lkp, 1'b0, '0, mPhase == 1);
  endtask

  // Monitor: compares the DUT against each predicted cycle, and update payloads against enqueue order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expCycle.size() > 0) begin
        e = expCycle.pop_front();
        checkOutput("lkp_gnt",  32'(o_lkp_gnt),     32'(e.gnt));
        checkOutput("bpu_stall", 32'(o_bpu_stall),  32'(e.stall));
        checkOutput("upd_rdy",  32'(o_upd_rdy),     32'(e.rdy));
        checkOutput("ftb_req",  32'(o_ftb_upd_req), 32'(e.req));
        checkOutput("q_count",  32'(o_q_count),     32'(e.count));
        if (e.req && o_ftb_upd_req) begin
          if (expUpd.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL upd_order: got %h expected no pending update", o_ftb_upd_info);
          end else begin
            checkInfo("upd_info", o_ftb_upd_info, expUpd[0]);
            if (e.pop) void'(expUpd.pop_front());
          end
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"},   32'(o_ftb_upd_req), 32'd0);
    checkOutput({tag, "_count"}, 32'(o_q_count),     32'd0);
    checkOutput({tag, "_rdy"},   32'(o_upd_rdy),     32'd1);
    checkOutput({tag, "_stall"}, 32'(o_bpu_stall),   32'd0);
    checkOutput({tag, "_gnt"},   32'(o_lkp_gnt),     32'd0);
    checkInfo({tag, "_info"}, o_ftb_upd_info, '0);
  endtask

  // Asynchronous reset in the middle of a cycle, away from any clock edge.
  task automatic doMidReset();
    @(negedge clk);
    i_lkp_req      = 1'b0;
    i_upd_vld      = 1'b0;
    i_ftb_upd_done = 1'b0;
    #1;
    checkOutput("pre_reset_req",   32'(o_ftb_upd_req), 32'(mPhase == 1));
    checkOutput("pre_reset_count", 32'(o_q_count),     32'(mCount));
    rst = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    mCount  = 0;
    mPhase  = 0;
    mStarve = 0;
    expUpd.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    rst            = 1'b0;
    i_lkp_req      = 1'b0;
    i_upd_vld      = 1'b0;
    i_upd_info     = '0;
    i_ftb_upd_done = 1'b0;
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] lookups with empty queue");
    idleCycles(1'b1, 20);

    $display("[TB] single update, done on second request cycle");
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    idleCycles(1'b0, 3);

    $display("[TB] starvation limit under continuous lookups");
    applyStimulus(1'b1, 1'b1, randInfo(), 1'b0);
    idleCycles(1'b1, 14);

    $display("[TB] fill queue under lookups, fifth request held");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, randInfo(), 1'b0);
    begin
      BPupdateInfo_t fifth;
      fifth = randInfo();
      applyStimulus(1'b1, 1'b1, fifth, 1'b0);
      applyStimulus(1'b1, 1'b1, fifth, 1'b0);
      applyStimulus(1'b1, 1'b1, fifth, 1'b1);
      applyStimulus(1'b1, 1'b1, fifth, 1'b0);
    end
    idleCycles(1'b1, 60);

    $display("[TB] enqueue and pop in the same cycle");
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b1);
    idleCycles(1'b0, 12);

    $display("[TB] reset while an update is in flight");
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b1, randInfo(), 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    doMidReset();
    idleCycles(1'b1, 6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic lkp, vld, done;
      lkp  = ($urandom_range(0, 3) != 0);
      vld  = ($urandom_range(0, 2) == 0);
      done = (mPhase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      applyStimulus(lkp, vld, randInfo(), done);
    end

    guard = 0;
    while ((mCount != 0 || mPhase != 0) && guard < 200) begin
      applyStimulus(1'b0, 1'b0, '0, mPhase == 1);
      guard++;
    end
    if (mCount != 0 || mPhase != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain_timeout: got %0d entries left expected 0", mCount);
    end
    @(negedge clk);
    #4;
    checkOutput("final_count", 32'(o_q_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
